// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI receive peripheral.
// Sample-edge selection is centralised here so every SPI mode resolves the same way.
package spi_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

   localparam int SPI_DEFAULT_TIMEOUT = 10000;

   // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
   function automatic logic sample_on_rising(input logic cpol, input logic cpha);
      return ((cpol ^ cpha) == 1'b0);
   endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO; the head word is visible whenever the FIFO is non-empty.
// A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
module spi_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [AW:0]       count_r;
   logic              pop_s;
   logic              push_s;

   assign full    = (count_r == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count_r == (AW+1)'(0));
   assign pop_s   = pop & ~empty;
   assign push_s  = push & (~full | pop_s);
   assign count   = count_r;
   assign rd_data = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

   // Storage, power-of-two wrapping pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/spi_peripheral_fifo.sv
// SPI receive peripheral: pin synchronisers, MSB-first shifter and IDLE/SHIFT framing FSM
// feeding an FWFT FIFO, with partial-word abort, inactivity timeout and sticky overflow.
module spi_peripheral_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int CPOL           = 0,
   parameter int CPHA           = 0,
   parameter int TIMEOUT_CYCLES = SPI_DEFAULT_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          SCLK,
   input  logic                          COPI,
   input  logic                          spi_cs_n,
   input  logic                          rx_enable,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          overflow_clr,
   output logic                          frame_abort,
   output logic                          busy
);

   localparam int   BC_W        = $clog2(DATA_W + 1);
   localparam int   TO_W        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic SAMPLE_RISE = sample_on_rising(1'(CPOL), 1'(CPHA));
   localparam logic SCLK_IDLE   = 1'(CPOL);

   logic              sclk_s1_r, sclk_s2_r, sclk_s3_r;
   logic              copi_s1_r, copi_s2_r;
   logic              cs_s1_r, cs_s2_r;
   spi_state_t        state_r, state_nxt_s;
   logic [BC_W-1:0]   bit_cnt_r;
   logic [DATA_W-1:0] shift_r;
   logic [TO_W-1:0]   tmo_cnt_r;
   logic              lock_r;
   logic              push_r;
   logic              frame_abort_r;
   logic              overflow_r;
   logic              edge_s, sample_s, leave_s, tmo_hit_s, word_done_s;
   logic              fifo_full_s, fifo_empty_s, pop_s, drop_s;

   // Two-stage synchronisers; SCLK gets a third stage so edges are seen on stable data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_s1_r <= SCLK_IDLE;
         sclk_s2_r <= SCLK_IDLE;
         sclk_s3_r <= SCLK_IDLE;
         copi_s1_r <= 1'b0;
         copi_s2_r <= 1'b0;
         cs_s1_r   <= 1'b1;
         cs_s2_r   <= 1'b1;
      end else begin
         sclk_s1_r <= SCLK;
         sclk_s2_r <= sclk_s1_r;
         sclk_s3_r <= sclk_s2_r;
         copi_s1_r <= COPI;
         copi_s2_r <= copi_s1_r;
         cs_s1_r   <= spi_cs_n;
         cs_s2_r   <= cs_s1_r;
      end
   end

   assign edge_s      = SAMPLE_RISE ? (sclk_s2_r & ~sclk_s3_r) : (~sclk_s2_r & sclk_s3_r);
   assign tmo_hit_s   = (bit_cnt_r != BC_W'(0)) && (tmo_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
   assign word_done_s = sample_s && (bit_cnt_r == BC_W'(DATA_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // A timed-out frame stays locked out until CS is released.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (!cs_s2_r && rx_enable && !lock_r) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (leave_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   always_comb begin
      leave_s  = 1'b0;
      sample_s = 1'b0;
      case (state_r)
         SHIFT: begin
            leave_s  = cs_s2_r | ~rx_enable | tmo_hit_s;
            sample_s = edge_s & ~leave_s;
         end
         IDLE: begin
            leave_s  = 1'b0;
            sample_s = 1'b0;
         end
         default: begin
            leave_s  = 1'b0;
            sample_s = 1'b0;
         end
      endcase
   end

   // Shifter, word strobe and abort pulse; the shifter is held cleared outside SHIFT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r     <= BC_W'(0);
         shift_r       <= {DATA_W{1'b0}};
         push_r        <= 1'b0;
         frame_abort_r <= 1'b0;
      end else begin
         push_r        <= word_done_s;
         frame_abort_r <= leave_s && (bit_cnt_r != BC_W'(0));
         if (leave_s || (state_r == IDLE)) begin
            bit_cnt_r <= BC_W'(0);
            shift_r   <= {DATA_W{1'b0}};
         end else if (sample_s) begin
            shift_r   <= {shift_r[DATA_W-2:0], copi_s2_r};
            bit_cnt_r <= word_done_s ? BC_W'(0) : (bit_cnt_r + BC_W'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= TO_W'(0);
         lock_r    <= 1'b0;
      end else begin
         if ((state_r == SHIFT) && (bit_cnt_r != BC_W'(0)) && !sample_s && !leave_s) begin
            tmo_cnt_r <= tmo_cnt_r + TO_W'(1);
         end else begin
            tmo_cnt_r <= TO_W'(0);
         end
         if (cs_s2_r) begin
            lock_r <= 1'b0;
         end else if ((state_r == SHIFT) && tmo_hit_s) begin
            lock_r <= 1'b1;
         end
      end
   end

   // shift_r still holds the completed word during the push cycle.
   spi_rx_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_r),
      .push_data (shift_r),
      .pop       (rx_ready),
      .rd_data   (rx_data),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count)
   );

   assign pop_s  = ~fifo_empty_s & rx_ready;
   assign drop_s = push_r & fifo_full_s & ~pop_s;

   // A dropped word wins over a clear request in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (overflow_clr) begin
         overflow_r <= 1'b0;
      end
   end

   assign rx_valid    = ~fifo_empty_s;
   assign overflow    = overflow_r;
   assign frame_abort = frame_abort_r;
   assign busy        = (state_r == SHIFT);

endmodule

// File: tb/tb_spi_peripheral_fifo.sv
// Drives a mode-0 8-bit and a mode-3 16-bit receiver from one bit stream and
// checks both against a word-queue reference model.
module tb_spi_peripheral_fifo;

   logic        clk = 1'b0;
   logic        rst_n, sclk0, sclk3, copi, cs_n, rx_en, rdy0, rdy3, ovf_clr;
   logic [7:0]  data0;
   logic [15:0] data3;
   logic [2:0]  cnt0, cnt3;
   logic        v0, v3, ovf0, ovf3, fa0, fa3, busy0, busy3;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int ab0    = 0;
   int ab3    = 0;
   int ab0_cyc = 0;
   int last_rise = 0;

   int          n [2];
   logic [31:0] acc [2];
   bit          lock_m [2];
   bit          ovf_m [2];
   int          exp_ab [2];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   always #5 clk = ~clk;

   spi_peripheral_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .TIMEOUT_CYCLES(50)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .SCLK(sclk0), .COPI(copi), .spi_cs_n(cs_n), .rx_enable(rx_en),
      .rx_data(data0), .rx_valid(v0), .rx_ready(rdy0), .fifo_count(cnt0), .overflow(ovf0),
      .overflow_clr(ovf_clr), .frame_abort(fa0), .busy(busy0));

   spi_peripheral_fifo #(.DATA_W(16), .FIFO_DEPTH(4), .CPOL(1), .CPHA(1), .TIMEOUT_CYCLES(50)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .SCLK(sclk3), .COPI(copi), .spi_cs_n(cs_n), .rx_enable(rx_en),
      .rx_data(data3), .rx_valid(v3), .rx_ready(rdy3), .fifo_count(cnt3), .overflow(ovf3),
      .overflow_clr(ovf_clr), .frame_abort(fa3), .busy(busy3));

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fa0) begin
         ab0     <= ab0 + 1;
         ab0_cyc <= cyc;
      end
      if (fa3) ab3 <= ab3 + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got hang expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_push(input int d, input logic [31:0] w);
      if (d == 0) begin
         if (q0.size() < 4) q0.push_back(w); else ovf_m[0] = 1'b1;
      end else begin
         if (q1.size() < 4) q1.push_back(w); else ovf_m[1] = 1'b1;
      end
   endtask

   task automatic model_bit(input logic b);
      for (int d = 0; d < 2; d++) begin
         if (!lock_m[d]) begin
            acc[d] = (acc[d] << 1) | 32'(b);
            n[d]++;
            if (n[d] == ((d == 0) ? 8 : 16)) begin
               model_push(d, acc[d]);
               n[d]   = 0;
               acc[d] = 32'h0;
            end
         end
      end
   endtask

   task automatic model_end(input bit timeout);
      for (int d = 0; d < 2; d++) begin
         if (n[d] != 0) begin
            exp_ab[d]++;
            if (timeout) lock_m[d] = 1'b1;
         end
         if (!timeout) lock_m[d] = 1'b0;
         n[d]   = 0;
         acc[d] = 32'h0;
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         n[d] = 0; acc[d] = 32'h0; lock_m[d] = 1'b0; ovf_m[d] = 1'b0;
      end
      q0.delete();
      q1.delete();
   endtask

   // ---------------- stimulus ----------------
   task automatic send_bit(input logic b);
      @(posedge clk); #1;
      copi = b; sclk0 = 1'b0; sclk3 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      sclk0 = 1'b1; sclk3 = 1'b1;
      last_rise = cyc;
      model_bit(b);
      repeat (3) @(posedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int nb);
      for (int i = nb - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic cs_low();
      @(posedge clk); #1;
      cs_n = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic end_frame();
      @(posedge clk); #1;
      sclk0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cs_n = 1'b1;
      model_end(1'b0);
      repeat (8) @(posedge clk);
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      check_eq({tag, "_cnt0"}, 32'(cnt0), 32'(q0.size()));
      check_eq({tag, "_cnt3"}, 32'(cnt3), 32'(q1.size()));
      check_eq({tag, "_ovf0"}, 32'(ovf0), 32'(ovf_m[0]));
      check_eq({tag, "_ovf3"}, 32'(ovf3), 32'(ovf_m[1]));
      check_eq({tag, "_abort0"}, 32'(ab0), 32'(exp_ab[0]));
      check_eq({tag, "_abort3"}, 32'(ab3), 32'(exp_ab[1]));
   endtask

   task automatic drain();
      for (int d = 0; d < 2; d++) begin
         int sz = (d == 0) ? q0.size() : q1.size();
         for (int k = 0; k < sz; k++) begin
            logic [31:0] e;
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            @(negedge clk);
            check_eq($sformatf("pop_valid%0d", d), (d == 0) ? 32'(v0) : 32'(v3), 32'h1);
            check_eq($sformatf("pop_data%0d", d), (d == 0) ? 32'(data0) : 32'(data3), e);
            if (d == 0) rdy0 = 1'b1; else rdy3 = 1'b1;
            @(negedge clk);
            rdy0 = 1'b0; rdy3 = 1'b0;
         end
         @(negedge clk);
         check_eq($sformatf("empty_valid%0d", d), (d == 0) ? 32'(v0) : 32'(v3), 32'h0);
         check_eq($sformatf("empty_data%0d", d), (d == 0) ? 32'(data0) : 32'(data3), 32'h0);
      end
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
   endtask

   // ---------------- sequence ----------------
   initial begin
      int base;
      int delay;
      rst_n = 1'b0; cs_n = 1'b1; sclk0 = 1'b0; sclk3 = 1'b1; copi = 1'b0;
      rx_en = 1'b1; rdy0 = 1'b0; rdy3 = 1'b0; ovf_clr = 1'b0;
      exp_ab[0] = 0; exp_ab[1] = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_valid0", 32'(v0), 32'h0);
      check_eq("rst_data0", 32'(data0), 32'h0);
      check_eq("rst_cnt0", 32'(cnt0), 32'h0);
      check_eq("rst_busy0", 32'(busy0), 32'h0);
      check_eq("rst_ovf3", 32'(ovf3), 32'h0);
      check_eq("rst_abort3", 32'(fa3), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // single mode-0 word with latency check on the final bit
      cs_low();
      send_word(32'h52, 7);
      @(posedge clk); #1;
      copi = 1'b1; sclk0 = 1'b0; sclk3 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      sclk0 = 1'b1; sclk3 = 1'b1;
      model_bit(1'b1);
      repeat (4) @(negedge clk);
      check_eq("lat_before", 32'(v0), 32'h0);
      @(negedge clk);
      check_eq("lat_valid", 32'(v0), 32'h1);
      check_eq("lat_data", 32'(data0), 32'hA5);
      check_eq("busy_in_frame", 32'(busy0), 32'h1);
      end_frame();
      check_status("t1");
      drain();

      // two 16-bit words in one frame, with a rx_enable pause at a word boundary
      cs_low();
      send_word(32'h1234, 16);
      send_word(32'hBEEF, 16);
      @(posedge clk); #1;
      rx_en = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check_eq("dis_busy0", 32'(busy0), 32'h0);
      check_eq("dis_busy3", 32'(busy3), 32'h0);
      check_eq("dis_keep0", 32'(cnt0), 32'h4);
      rx_en = 1'b1;
      repeat (4) @(posedge clk);
      end_frame();
      check_status("t2");
      drain();

      // overflow with consumer stalled
      cs_low();
      for (int i = 1; i <= 5; i++) send_word(32'(i), 8);
      end_frame();
      check_status("t3");
      check_eq("ovf_head0", 32'(data0), 32'h01);
      pulse_clr();
      @(negedge clk);
      check_eq("ovf_clr0", 32'(ovf0), 32'h0);
      drain();

      // partial word abort, then a clean word
      cs_low();
      send_word(32'h5, 3);
      end_frame();
      check_status("t4a");
      cs_low();
      send_word(32'h3C, 8);
      end_frame();
      check_status("t4b");
      drain();

      // inactivity timeout and lockout until CS toggles
      cs_low();
      send_word(32'h15, 5);
      base = ab0;
      for (int i = 0; i < 100 && ab0 == base; i++) @(negedge clk);
      model_end(1'b1);
      delay = ab0_cyc - last_rise;
      check_eq("tmo_seen", 32'(ab0 != base), 32'h1);
      check_eq("tmo_delay_in_50_56", 32'(delay >= 50 && delay <= 56), 32'h1);
      check_eq("tmo_busy0", 32'(busy0), 32'h0);
      check_eq("tmo_busy3", 32'(busy3), 32'h0);
      send_word(32'hFF, 8);
      check_status("t5a");
      end_frame();
      cs_low();
      send_word(32'h5A, 8);
      end_frame();
      check_status("t5b");
      drain();

      // reset mid-word with words buffered
      cs_low();
      send_word(32'hC3, 8);
      send_word(32'h96, 8);
      send_word(32'h3, 3);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid0", 32'(v0), 32'h0);
      check_eq("mid_rst_valid3", 32'(v3), 32'h0);
      check_eq("mid_rst_cnt0", 32'(cnt0), 32'h0);
      check_eq("mid_rst_data3", 32'(data3), 32'h0);
      check_eq("mid_rst_busy0", 32'(busy0), 32'h0);
      model_reset();
      cs_n = 1'b1; sclk0 = 1'b0; sclk3 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      check_status("t6a");
      cs_low();
      send_word(32'hE7, 8);
      end_frame();
      check_status("t6b");
      drain();

      // randomized frames of random length
      for (int it = 0; it < 6; it++) begin
         int nb;
         pulse_clr();
         cs_low();
         nb = int'($urandom_range(1, 40));
         for (int k = 0; k < nb; k++) send_bit(1'($urandom_range(0, 1)));
         end_frame();
         check_status($sformatf("rnd%0d", it));
         drain();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_peripheral_fifo.md
Name: spi_peripheral_fifo

Overview:
Parametrised successor SPI receive peripheral: all four SPI modes, configurable frame width, CS-framed multi-word bursts.
Received words go into an internal FWFT FIFO drained via valid/ready, so the consumer no longer stalls the link word-by-word.
Adds partial-frame abort, inactivity timeout and sticky overflow reporting.
Sits between the board SPI pins and the image/command loader.

Parameters:
DATA_W, 8, bits per SPI word (4..32)
FIFO_DEPTH, 4, RX FIFO entries (power of two, >=2)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
TIMEOUT_CYCLES, 10000, clk cycles without a sample edge mid-word before abort (>0)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock, asynchronous to clk
COPI  in  1  controller-out data
spi_cs_n  in  1  chip select, active low
rx_enable  in  1  1 = accept bits; 0 = shifter held cleared
rx_data  out  DATA_W  FIFO head word
rx_valid  out  1  head word available
rx_ready  in  1  consumer pops head when rx_valid=1
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: a completed word was dropped
overflow_clr  in  1  clears overflow
frame_abort  out  1  1-cycle pulse: partial word discarded
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; bit_cnt=0; shift_reg=0; FIFO empty; rx_valid=0, rx_data=0, fifo_count=0, overflow=0, frame_abort=0, busy=0.
- Sync registers for SCLK reset to CPOL; COPI and CS sync registers reset to 0 and 1 respectively.
- Synchronisers: SCLK, COPI and spi_cs_n each pass through 2 flops. SCLK gets a third flop for edge detection. No raw pin reaches logic.
- Sample edge:
  - CPOL^CPHA=0: rising edge of synchronised SCLK.
  - CPOL^CPHA=1: falling edge.
  - Only sample edges act; the other edge is ignored.
- Timing requirement: clk >= 8x SCLK.
- Shifting: MSB first. On a detected sample edge, shift_reg <= {shift_reg[DATA_W-2:0], copi_sync}; bit_cnt increments.
- Word completion: on the sample edge that makes bit_cnt reach DATA_W:
  - a push strobe is registered and bit_cnt wraps to 0;
  - the word is written to the FIFO on the next clk.
  - Latency: edge detected in cycle T → rx_valid=1 at T+2 (empty FIFO).
- FSM states: IDLE, SHIFT.
  - IDLE→SHIFT: cs_sync=0 and rx_enable=1.
  - SHIFT→IDLE: cs_sync=1, rx_enable=0, or timeout.
  - Leaving SHIFT with bit_cnt!=0 pulses frame_abort for exactly 1 cycle and clears bit_cnt and shift_reg.
  - Leaving SHIFT with bit_cnt=0 gives no pulse.
- Back-to-back words: CS held low → continuous words, no idle gap needed. A sample edge in the push cycle is bit 0 of the next word.
- Timeout: a counter runs in SHIFT while bit_cnt!=0 and resets on every sample edge. On reaching TIMEOUT_CYCLES it aborts as above and moves to IDLE. Re-entry requires CS high then low again.
- FIFO (FWFT):
  - rx_data is the head word; it reads 0 when empty.
  - A pop occurs when rx_valid & rx_ready.
  - Push and pop in the same cycle leave fifo_count unchanged; this holds even when full.
  - Push when full without a pop: the word is dropped, overflow is set, and FIFO contents are untouched.
  - rx_ready while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set has priority over overflow_clr in the same cycle. Otherwise it is cleared by overflow_clr.
- rx_enable=0: the FIFO keeps draining; buffered words are retained.

Decomposition:
- Package spi_pkg holds:
  - spi_state_t enum {IDLE, SHIFT};
  - the sample-edge select function of (CPOL, CPHA);
  - SPI_DEFAULT_TIMEOUT constant.
- One sub-module, spi_rx_fifo: parametrised DATA_W/FIFO_DEPTH FWFT FIFO with push, pop, full, empty, count.
- Synchronisers, shifter and FSM live in the top.

Test Plan:
- Mode 0, DATA_W=8, CS low, send 0xA5 → rx_valid=1 two clk after the final synchronised rising edge, rx_data=0xA5, fifo_count=1; pop → rx_valid=0, rx_data=0.
- Mode 3 (CPOL=1, CPHA=1), DATA_W=16, send 0x1234 then 0xBEEF in one CS frame → FIFO holds 0x1234, 0xBEEF in order; no frame_abort.
- rx_ready=0, DEPTH=4, send 5 words 0x01..0x05 → fifo_count=4, overflow=1, head=0x01, 0x05 lost; overflow_clr → overflow=0.
- Send 3 bits then deassert CS → one frame_abort pulse, FIFO unchanged; next full word 0x3C is received correctly.
- TIMEOUT_CYCLES=50, stop SCLK after 5 bits with CS low → frame_abort at 50 cycles after the last edge, busy=0; further edges are ignored until CS toggles.
- Assert rst_n=0 mid-word with 2 words buffered → all outputs at reset values immediately; no spurious edge or word after release.
